// File: rtl/spi_target_sim.sv
// SPI target that oversamples sclk/pico/cs on the system clock, receives MSB-first bytes and answers on poci.
// Define SPI_TARGET_SIM_LOOPBACK_EN to echo the last received byte whenever no transmit byte is held.

module spi_target_sim #(
    parameter bit         CPOL      = 1'b0,
    parameter bit         CPHA      = 1'b0,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sclk,
    input  logic       pico,
    input  logic       cs,
    output logic       poci,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t     state;

    logic [2:0] sclk_sync;
    logic [2:0] pico_sync;
    logic [2:0] cs_sync;
    logic       lead_q;
    logic       trail_q;
    logic       cs_fall_q;
    logic       cs_rise_q;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] hold;
    logic       full;
    logic       first_shift;

    logic       pico_s;
    logic       sample_edge;
    logic       shift_edge;
    logic       accept;
    logic       frame_load;
    logic [7:0] rx_next;
    logic [7:0] fill_byte;
    logic [7:0] load_byte;

    // Stages [0],[1] synchronise the pins; stage [2] is the previous value used for edge detection.
    // Edges are registered, so the core acts one cycle after they are detected.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sync <= {3{CPOL}};
            pico_sync <= 3'b000;
            cs_sync   <= 3'b111;
            lead_q    <= 1'b0;
            trail_q   <= 1'b0;
            cs_fall_q <= 1'b0;
            cs_rise_q <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            pico_sync <= {pico_sync[1:0], pico};
            cs_sync   <= {cs_sync[1:0], cs};
            lead_q    <= (sclk_sync[1] != sclk_sync[2]) && (sclk_sync[1] != CPOL);
            trail_q   <= (sclk_sync[1] != sclk_sync[2]) && (sclk_sync[1] == CPOL);
            cs_fall_q <= ~cs_sync[1] & cs_sync[2];
            cs_rise_q <= cs_sync[1] & ~cs_sync[2];
        end
    end

    assign pico_s      = pico_sync[2];
    assign sample_edge = CPHA ? trail_q : lead_q;
    assign shift_edge  = CPHA ? lead_q : trail_q;
    assign rx_next     = {rx_shift[6:0], pico_s};
    assign accept      = tx_valid & ~full;
    assign frame_load  = (state == IDLE) ? cs_fall_q
                                         : (~cs_rise_q & sample_edge & (bit_cnt == 3'd7));

`ifdef SPI_TARGET_SIM_LOOPBACK_EN
    // At a byte boundary the just-completed byte is echoed, not the stale rx_data.
    assign fill_byte = (state == IDLE) ? rx_data : rx_next;
`else
    assign fill_byte = IDLE_BYTE;
`endif

    assign load_byte = full ? hold : fill_byte;
    assign tx_ready  = ~full;
    assign busy      = (state == ACTIVE);

    // A load in the same cycle as an accept sees the holding register empty, so the
    // accepted byte survives for the following frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            hold        <= 8'h00;
            full        <= 1'b0;
            first_shift <= 1'b0;
            poci        <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (accept) begin
                hold <= tx_data;
                full <= 1'b1;
            end else if (frame_load) begin
                full <= 1'b0;
            end

            if (frame_load) begin
                tx_shift    <= load_byte;
                first_shift <= 1'b1;
                if (!CPHA) begin
                    poci <= load_byte[7];
                end
            end

            case (state)
                IDLE: begin
                    if (cs_fall_q) begin
                        state   <= ACTIVE;
                        bit_cnt <= 3'd0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise_q) begin
                        state       <= IDLE;
                        bit_cnt     <= 3'd0;
                        poci        <= 1'b0;
                        first_shift <= 1'b0;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                        end
                    end else if (shift_edge) begin
                        if (CPHA && first_shift) begin
                            poci        <= tx_shift[7];
                            first_shift <= 1'b0;
                        end else if (CPHA || (bit_cnt != 3'd0)) begin
                            poci     <= tx_shift[6];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_target_sim.md
# spi_target_sim

Simulation and FPGA-test SPI target (peripheral) that answers the SoC's SPI controller on `sclk`/`pico`/`poci`/`cs`. It oversamples the controller's pins on the system clock, deserialises 8-bit frames MSB-first onto a byte-strobe interface, and serialises bytes supplied through a ready/valid interface back on `poci`. It sits next to the SoC in the Verilator harness and board loopback tests, connected pin-to-pin to the controller.

## Interface
- `CPOL`, default 0: idle level of `sclk`.
- `CPHA`, default 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- `IDLE_BYTE`, default 8'hFF: byte shifted out when no transmit byte is available.
- `clock` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `sclk` input, 1 bit: SPI clock from the controller. Asynchronous to `clock`.
- `pico` input, 1 bit: controller-to-target data.
- `cs` input, 1 bit: chip select, active low.
- `poci` output, 1 bit: target-to-controller data.
- `tx_data` input, 8 bits: next byte to send.
- `tx_valid` input, 1 bit: `tx_data` is valid.
- `tx_ready` output, 1 bit: holding register is empty. Transfer occurs when `tx_valid & tx_ready`.
- `rx_data` output, 8 bits: last complete received byte. Held until the next byte completes.
- `rx_valid` output, 1 bit: one-cycle pulse when `rx_data` updates.
- `busy` output, 1 bit: synchronised `cs` is low.

## Operation
- **Input synchronisation:** `sclk`, `pico` and `cs` each pass through a 2-flop synchroniser followed by one edge-detect register. All internal logic uses the synchronised versions only.
- **Edge definitions:**
  - Leading edge = synchronised `sclk` leaving the `CPOL` level. Trailing edge = returning to it.
  - Sample edge = leading edge if `CPHA=0`, else trailing edge. Shift edge = the other one.
- **States:**
  - IDLE: `cs` high. `poci=0`, bit counter = 0.
  - ACTIVE: `cs` low. Transition to ACTIVE on the synchronised `cs` falling edge; back to IDLE on the rising edge.
- **Frame load:**
  - Occurs on entry to ACTIVE, and again on the sample edge that completes bit 8 while `cs` stays low.
  - If the holding register is full, its byte moves into the shift register and the holding register empties.
  - Otherwise the shift register loads `IDLE_BYTE`, or the loopback byte (see Configuration).
- **Driving `poci`:**
  - `CPHA=0`: MSB appears at load. Each shift edge advances to the next bit.
  - `CPHA=1`: the first shift edge presents the MSB and later shift edges advance.
  - In both modes, a shift edge occurring after the 8th sample is ignored when `CPHA=0`; the frame load sets the next MSB instead.
- **Receive:**
  - Each sample edge shifts synchronised `pico` in at the LSB and increments the 3-bit counter.
  - On the 8th sample, `rx_data` is written and `rx_valid` pulses; the counter wraps to 0.
- **Holding register:**
  - Single entry. `tx_ready = ~full`.
  - An accept and a frame load in the same cycle are legal. The load sees an empty register and uses the idle/loopback byte; the accepted byte then stays held for the following frame.
- **`cs` deasserted mid-byte:**
  - Counter clears and the partial receive byte is discarded, with no `rx_valid`.
  - The byte in the shift register is lost. The holding register is untouched.
  - `poci` returns to 0.
- **`sclk` edges while `cs` is high** are ignored.

## Timing
- Reset values:
  - `poci` = 0, `tx_ready` = 1, `rx_data` = 8'h00, `rx_valid` = 0, `busy` = 0.
  - Shift register, counter and holding register cleared. Synchronisers reset to `CPOL`/0/1 for `sclk`/`pico`/`cs` respectively.
- Pin-to-internal edge latency: 3 `clock` cycles.
- `poci` changes 4 cycles after the pin edge that causes the shift or load.
- `rx_valid` asserts 4 cycles after the 8th pin-level sample edge.
- Supported `sclk` frequency ≤ `clock`/8. Each `sclk` half period must be ≥ 4 `clock` cycles.
- `cs` must fall ≥ 4 `clock` cycles before the first `sclk` edge.
- `tx_ready` falls the cycle after an accept and rises the cycle after a frame load.

## Configuration
- `SPI_TARGET_SIM_LOOPBACK_EN`:
  - Defined: when the holding register is empty at a frame load, the shift register loads the last completed `rx_data` instead of `IDLE_BYTE`. This provides a self-checking echo.
  - Undefined: `IDLE_BYTE` is used.

## Test plan
- **Mode 0 single byte:** controller sends 8'hA5 with 8'h3C preloaded via `tx_valid` → `rx_data`=8'hA5 with one `rx_valid` pulse; controller reads 8'h3C; `tx_ready` returns to 1.
- **Mode 3 (`CPOL=1`, `CPHA=1`) back-to-back:** 3 bytes 8'h01, 8'h80, 8'hFF under one `cs` low, with only 8'h55 preloaded → received in order with 3 pulses; controller reads 8'h55, 8'hFF, 8'hFF (macro off).
- **Loopback macro defined:** send 8'h12 then 8'h34 with no tx bytes → second read returns 8'h12.
- **`cs` raised after 5 bits:** no `rx_valid`, `poci`=0 after 4 cycles; the next full frame receives 8'hC3 correctly.
- **Simultaneous accept and load:** `tx_valid` with 8'h77 in the same cycle as the frame load → current frame sends 8'hFF, next frame sends 8'h77.
- **Reset mid-frame:** assert `reset` after 4 bits → all outputs return to reset values immediately; the next frame completes normally.
